// File: rtl/ifm_pingpong_buffer_pkg.sv
// Shared LeNet5 parameters and types for the IFM ping-pong buffer:
// word/map defaults, consumer FSM encoding and read-source selection.
package ifm_pingpong_buffer_pkg;

    localparam int IFM_DATA_WIDTH = 32;
    localparam int IFM_SIDE       = 14;
    localparam int IFM_ADDR_WIDTH = $clog2(IFM_SIDE * IFM_SIDE);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } cons_state_e;

    // Which registered value a read port presents: a bank's read register or zero.
    typedef enum logic [1:0] {
        SRC_ZERO  = 2'd0,
        SRC_BANK0 = 2'd1,
        SRC_BANK1 = 2'd2
    } rd_src_e;

    function automatic rd_src_e bank_src(input logic bank);
        return bank ? SRC_BANK1 : SRC_BANK0;
    endfunction

endpackage

// File: rtl/ifm_pingpong_buffer_if.sv
// Producer/consumer handshake and data bus of the IFM ping-pong buffer.
// The buffer uses the slave modport; the environment driving it uses master.
interface ifm_pingpong_buffer_if
    import ifm_pingpong_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = IFM_DATA_WIDTH,
    parameter int ADDRESS_SIZE = IFM_ADDR_WIDTH
);

    logic                    start_from_previous;
    logic                    ifm_enable_write;
    logic                    ifm_sel;
    logic [ADDRESS_SIZE-1:0] ifm_address_write;
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    end_to_previous;

    logic                    start_to_next;
    logic                    end_from_next;
    logic                    ifm_enable_read_A;
    logic [ADDRESS_SIZE-1:0] ifm_address_read_A;
    logic                    ifm_enable_read_B;
    logic [ADDRESS_SIZE-1:0] ifm_address_read_B;
    logic [DATA_WIDTH-1:0]   data_out_A;
    logic [DATA_WIDTH-1:0]   data_out_B;
    logic                    error;

    modport slave (
        input  start_from_previous, ifm_enable_write, ifm_sel, ifm_address_write, data_in,
        input  end_from_next, ifm_enable_read_A, ifm_address_read_A,
        input  ifm_enable_read_B, ifm_address_read_B,
        output end_to_previous, start_to_next, data_out_A, data_out_B, error
    );

    modport master (
        output start_from_previous, ifm_enable_write, ifm_sel, ifm_address_write, data_in,
        output end_from_next, ifm_enable_read_A, ifm_address_read_A,
        output ifm_enable_read_B, ifm_address_read_B,
        input  end_to_previous, start_to_next, data_out_A, data_out_B, error
    );

endinterface

// File: rtl/ifm_bank_ram.sv
// One feature-map bank: single write port and two synchronous read ports,
// each read register updating only when its enable is high.
module ifm_bank_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 196,
    parameter int ADDRESS_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [ADDRESS_SIZE-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic                    re_a_i,
    input  logic [ADDRESS_SIZE-1:0] raddr_a_i,
    output logic [DATA_WIDTH-1:0]   rdata_a_o,
    input  logic                    re_b_i,
    input  logic [ADDRESS_SIZE-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0]   rdata_b_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_a_q;
    logic [DATA_WIDTH-1:0] rdata_b_q;

    // NOTE: storage and read registers have no reset so this maps onto block RAM;
    // the top level masks the read data to zero until a real read has happened.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_a_i) begin
            rdata_a_q <= mem_q[raddr_a_i];
        end
        if (re_b_i) begin
            rdata_b_q <= mem_q[raddr_b_i];
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/ifm_pingpong_buffer.sv
// Two-bank IFM ping-pong buffer: producer fills one bank while the consumer
// reads the other; full flags, bank pointers and a consumer FSM track ownership.
module ifm_pingpong_buffer
    import ifm_pingpong_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = IFM_DATA_WIDTH,
    parameter int IFM_SIZE     = IFM_SIDE,
    parameter int ADDRESS_SIZE = $clog2(IFM_SIZE * IFM_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    ifm_pingpong_buffer_if.slave  bus
);

    localparam int unsigned DEPTH = IFM_SIZE * IFM_SIZE;

    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic [1:0]  full_q, full_d;
    logic        error_q, error_d;
    rd_src_e     src_a_q, src_a_d;
    rd_src_e     src_b_q, src_b_d;
    cons_state_e state_q;
    logic        start_to_next_q;

    logic                    wr_in_range, rd_a_in_range, rd_b_in_range;
    logic [1:0]              bank_we, bank_re_a, bank_re_b;
    logic [DATA_WIDTH-1:0]   rdata_a [2];
    logic [DATA_WIDTH-1:0]   rdata_b [2];
    logic [DATA_WIDTH-1:0]   data_a, data_b;

    assign wr_in_range   = 32'(bus.ifm_address_write)  < DEPTH;
    assign rd_a_in_range = 32'(bus.ifm_address_read_A) < DEPTH;
    assign rd_b_in_range = 32'(bus.ifm_address_read_B) < DEPTH;

    // NOTE: every variable gets its hold value first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        error_d   = error_q;
        if (bus.ifm_enable_write && full_q[bus.ifm_sel]) begin
            error_d = 1'b1;
        end
        if (bus.start_from_previous) begin
            if (full_q[wr_bank_q]) begin
                error_d = 1'b1;
            end else begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
        // A set and a clear in the same cycle always hit different banks.
        if (bus.end_from_next) begin
            if (state_q == ST_BUSY) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                error_d = 1'b1;
            end
        end
    end

    always_comb begin
        src_a_d = src_a_q;
        src_b_d = src_b_q;
        if (bus.ifm_enable_read_A) begin
            src_a_d = rd_a_in_range ? bank_src(rd_bank_q) : SRC_ZERO;
        end
        if (bus.ifm_enable_read_B) begin
            src_b_d = rd_b_in_range ? bank_src(rd_bank_q) : SRC_ZERO;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            error_q   <= 1'b0;
            src_a_q   <= SRC_ZERO;
            src_b_q   <= SRC_ZERO;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            error_q   <= error_d;
            src_a_q   <= src_a_d;
            src_b_q   <= src_b_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            start_to_next_q <= 1'b0;
        end else begin
            start_to_next_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        start_to_next_q <= 1'b1;
                        state_q         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.end_from_next) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        assign bank_we[g]   = bus.ifm_enable_write && (bus.ifm_sel == 1'(g))
                              && !full_q[g] && wr_in_range;
        assign bank_re_a[g] = bus.ifm_enable_read_A && rd_a_in_range && (rd_bank_q == 1'(g));
        assign bank_re_b[g] = bus.ifm_enable_read_B && rd_b_in_range && (rd_bank_q == 1'(g));

        ifm_bank_ram #(
            .DATA_WIDTH   (DATA_WIDTH),
            .DEPTH        (DEPTH),
            .ADDRESS_SIZE (ADDRESS_SIZE)
        ) u_bank (
            .clk       (clk),
            .we_i      (bank_we[g]),
            .waddr_i   (bus.ifm_address_write),
            .wdata_i   (bus.data_in),
            .re_a_i    (bank_re_a[g]),
            .raddr_a_i (bus.ifm_address_read_A),
            .rdata_a_o (rdata_a[g]),
            .re_b_i    (bank_re_b[g]),
            .raddr_b_i (bus.ifm_address_read_B),
            .rdata_b_o (rdata_b[g])
        );
    end

    always_comb begin
        case (src_a_q)
            SRC_BANK0: data_a = rdata_a[0];
            SRC_BANK1: data_a = rdata_a[1];
            default:   data_a = '0;
        endcase
        case (src_b_q)
            SRC_BANK0: data_b = rdata_b[0];
            SRC_BANK1: data_b = rdata_b[1];
            default:   data_b = '0;
        endcase
    end

    assign bus.data_out_A      = data_a;
    assign bus.data_out_B      = data_b;
    assign bus.start_to_next   = start_to_next_q;
    assign bus.end_to_previous = ~full_q[wr_bank_q];
    assign bus.error           = error_q;

endmodule

// File: tb/tb_ifm_pingpong_buffer.sv
// Directed self-checking bench for ifm_pingpong_buffer (default 14x14 map, 32-bit words).
module tb_ifm_pingpong_buffer;
    import ifm_pingpong_buffer_pkg::*;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    ifm_pingpong_buffer_if bus ();

    ifm_pingpong_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic sel, input logic [7:0] addr, input logic [31:0] data);
        bus.ifm_enable_write  = 1'b1;
        bus.ifm_sel           = sel;
        bus.ifm_address_write = addr;
        bus.data_in           = data;
        tick();
        bus.ifm_enable_write  = 1'b0;
    endtask

    task automatic read_a(input logic [7:0] addr);
        bus.ifm_enable_read_A  = 1'b1;
        bus.ifm_address_read_A = addr;
        tick();
        bus.ifm_enable_read_A  = 1'b0;
    endtask

    initial begin
        bus.start_from_previous = 1'b0;
        bus.ifm_enable_write    = 1'b0;
        bus.ifm_sel             = 1'b0;
        bus.ifm_address_write   = '0;
        bus.data_in             = '0;
        bus.end_from_next       = 1'b0;
        bus.ifm_enable_read_A   = 1'b0;
        bus.ifm_address_read_A  = '0;
        bus.ifm_enable_read_B   = 1'b0;
        bus.ifm_address_read_B  = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_end_to_previous", 64'(bus.end_to_previous), 64'd1);
        chk("rst_start_to_next",   64'(bus.start_to_next),   64'd0);
        chk("rst_data_out_A",      64'(bus.data_out_A),      64'd0);
        chk("rst_data_out_B",      64'(bus.data_out_B),      64'd0);
        chk("rst_error",           64'(bus.error),           64'd0);
        reset = 1'b1;
        tick();

        // end_from_next while IDLE: error, pointers untouched, error sticky
        bus.end_from_next = 1'b1;
        tick();
        bus.end_from_next = 1'b0;
        chk("idle_end_error",   64'(bus.error),       64'd1);
        chk("idle_end_rd_bank", 64'(dut.rd_bank_q),   64'd0);
        chk("idle_end_wr_bank", 64'(dut.wr_bank_q),   64'd0);
        chk("idle_end_state",   64'(dut.state_q),     64'(ST_IDLE));
        tick();
        tick();
        tick();
        chk("error_sticky", 64'(bus.error), 64'd1);
        reset = 1'b0;
        #1;
        chk("error_cleared_by_reset", 64'(bus.error), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Fill bank 0 with data = addr, announce it, read back on both ports
        for (int a = 0; a < 196; a++) begin
            write_word(1'b0, 8'(a), 32'(a));
        end
        chk("fill0_end_to_previous", 64'(bus.end_to_previous), 64'd1);
        bus.start_from_previous = 1'b1;
        tick();
        bus.start_from_previous = 1'b0;
        chk("announce0_no_pulse_yet", 64'(bus.start_to_next), 64'd0);
        chk("announce0_full",         64'(dut.full_q),         64'b01);
        tick();
        chk("announce0_pulse", 64'(bus.start_to_next), 64'd1);
        bus.ifm_enable_read_A  = 1'b1;
        bus.ifm_address_read_A = 8'd5;
        bus.ifm_enable_read_B  = 1'b1;
        bus.ifm_address_read_B = 8'd195;
        tick();
        bus.ifm_enable_read_A  = 1'b0;
        bus.ifm_enable_read_B  = 1'b0;
        chk("announce0_pulse_one_cycle", 64'(bus.start_to_next), 64'd0);
        chk("read_A_addr5",   64'(bus.data_out_A), 64'd5);
        chk("read_B_addr195", 64'(bus.data_out_B), 64'd195);
        tick();
        chk("hold_A", 64'(bus.data_out_A), 64'd5);
        chk("hold_B", 64'(bus.data_out_B), 64'd195);
        read_a(8'd200);
        chk("read_out_of_range", 64'(bus.data_out_A), 64'd0);
        chk("hold_B_other_port", 64'(bus.data_out_B), 64'd195);

        // Fill bank 1 while consumer still owns bank 0
        for (int a = 0; a < 196; a++) begin
            write_word(1'b1, 8'(a), 32'(a + 1000));
        end
        bus.start_from_previous = 1'b1;
        tick();
        bus.start_from_previous = 1'b0;
        chk("both_full_end_to_previous", 64'(bus.end_to_previous), 64'd0);
        chk("both_full_flags",           64'(dut.full_q),          64'b11);
        tick();
        chk("both_full_no_pulse_busy", 64'(bus.start_to_next), 64'd0);
        chk("no_error_before_bad_write", 64'(bus.error), 64'd0);

        // Write into full bank 0 is dropped and flagged
        write_word(1'b0, 8'd5, 32'hDEAD);
        chk("write_full_error", 64'(bus.error), 64'd1);
        read_a(8'd5);
        chk("write_full_unchanged", 64'(bus.data_out_A), 64'd5);

        // Release bank 0: producer sees it free, bank 1 gets announced
        bus.end_from_next = 1'b1;
        tick();
        bus.end_from_next = 1'b0;
        chk("release0_end_to_previous", 64'(bus.end_to_previous), 64'd1);
        chk("release0_no_pulse_yet",    64'(bus.start_to_next),   64'd0);
        chk("release0_rd_bank",         64'(dut.rd_bank_q),       64'd1);
        tick();
        chk("announce1_pulse", 64'(bus.start_to_next), 64'd1);
        read_a(8'd7);
        chk("read_bank1_addr7", 64'(bus.data_out_A), 64'd1007);

        // Build up: bank 0 busy with wr_bank=1, then simultaneous set/clear
        bus.end_from_next = 1'b1;
        tick();
        bus.end_from_next = 1'b0;
        write_word(1'b0, 8'd3, 32'd2003);
        bus.start_from_previous = 1'b1;
        tick();
        bus.start_from_previous = 1'b0;
        tick();
        chk("announce0b_pulse", 64'(bus.start_to_next), 64'd1);
        write_word(1'b1, 8'd4, 32'd3004);
        bus.start_from_previous = 1'b1;
        bus.end_from_next       = 1'b1;
        tick();
        bus.start_from_previous = 1'b0;
        bus.end_from_next       = 1'b0;
        chk("same_cycle_full",    64'(dut.full_q),      64'b10);
        chk("same_cycle_rd_bank", 64'(dut.rd_bank_q),   64'd1);
        chk("same_cycle_wr_bank", 64'(dut.wr_bank_q),   64'd0);
        tick();
        chk("same_cycle_pulse", 64'(bus.start_to_next), 64'd1);
        read_a(8'd4);
        chk("read_bank1_addr4", 64'(bus.data_out_A), 64'd3004);

        // Reset while BUSY with both banks full
        write_word(1'b0, 8'd0, 32'd77);
        bus.start_from_previous = 1'b1;
        tick();
        bus.start_from_previous = 1'b0;
        chk("pre_reset_full",            64'(dut.full_q),          64'b11);
        chk("pre_reset_end_to_previous", 64'(bus.end_to_previous), 64'd0);
        #2 reset = 1'b0;
        #1;
        chk("midreset_end_to_previous", 64'(bus.end_to_previous), 64'd1);
        chk("midreset_error",           64'(bus.error),           64'd0);
        chk("midreset_data_out_A",      64'(bus.data_out_A),      64'd0);
        chk("midreset_start_to_next",   64'(bus.start_to_next),   64'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_reset_no_pulse", 64'(bus.start_to_next), 64'd0);
        end
        chk("post_reset_end_to_previous", 64'(bus.end_to_previous), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifm_pingpong_buffer.md
IFM_PINGPONG_BUFFER -- requirements
Module: ifm_pingpong_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width.
REQ-002 Parameter IFM_SIZE, default 14, feature-map side length, producer-stage output size.
REQ-003 Parameter ADDRESS_SIZE, default $clog2(IFM_SIZE*IFM_SIZE), bank address width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as in the codebase:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
REQ-005 Producer-side ports SHALL be:
- start_from_previous  input  1  pulse: selected bank completely written.
- ifm_enable_write  input  1  write strobe.
- ifm_sel  input  1  bank written by producer.
- ifm_address_write  input  ADDRESS_SIZE  write address.
- data_in  input  DATA_WIDTH  write data.
- end_to_previous  output  1  level: bank at write pointer is free.
REQ-006 Consumer-side ports SHALL be:
- start_to_next  output  1  pulse: bank ready for consumer.
- end_from_next  input  1  pulse: consumer finished with bank.
- ifm_enable_read_A  input  1  port A read enable.
- ifm_address_read_A  input  ADDRESS_SIZE  port A read address.
- ifm_enable_read_B  input  1  port B read enable.
- ifm_address_read_B  input  ADDRESS_SIZE  port B read address.
- data_out_A  output  DATA_WIDTH  port A read data.
- data_out_B  output  DATA_WIDTH  port B read data.
- error  output  1  sticky protocol-violation flag.

Function
REQ-007 The block SHALL contain two banks of IFM_SIZE*IFM_SIZE words, with registers wr_bank, rd_bank and full[1:0].
REQ-008 A write with ifm_enable_write=1 SHALL store data_in at ifm_address_write in bank ifm_sel on that edge, but only if full[ifm_sel]=0; a write to a full bank SHALL be dropped and SHALL set error.
REQ-009 start_from_previous=1 SHALL set full[wr_bank] and toggle wr_bank; if full[wr_bank] is already 1, the pulse SHALL be ignored and SHALL set error.
REQ-010 end_to_previous SHALL be combinational ~full[wr_bank].
REQ-011 The consumer FSM SHALL have states IDLE and BUSY:
- IDLE with full[rd_bank]=1 -> registered start_to_next pulse exactly one cycle, go to BUSY.
- BUSY with end_from_next=1 -> clear full[rd_bank], toggle rd_bank, go to IDLE.
REQ-012 end_from_next in IDLE SHALL be ignored and SHALL set error.
REQ-013 A start_from_previous and an end_from_next in the same cycle SHALL both take effect; set and clear target different banks by construction.
REQ-014 Reads SHALL always address bank rd_bank.
REQ-015 data_out_A and data_out_B SHALL be registered with 1-cycle latency; each SHALL hold its value when its enable is 0.
REQ-016 Minimum latency from start_from_previous to start_to_next SHALL be 2 cycles (full set, then FSM pulse).
REQ-017 A bank released by end_from_next SHALL drive end_to_previous high in the next cycle if wr_bank points at it.
REQ-018 Out-of-range addresses (>= IFM_SIZE*IFM_SIZE) SHALL be dropped on write and SHALL read as 0.
REQ-019 error SHALL be sticky until reset.

Reset
REQ-020 While reset=0, the block SHALL asynchronously clear wr_bank=0, rd_bank=0, full=2'b00, FSM=IDLE, start_to_next=0, data_out_A=0, data_out_B=0 and error=0; end_to_previous SHALL therefore be 1.
REQ-021 Bank memory contents SHALL NOT be reset.
REQ-022 A reset mid-frame SHALL discard all bank status, so data written before reset is never announced to the consumer.

Structure
REQ-023 DATA_WIDTH and IFM_SIZE defaults and the FSM state encoding SHALL live in the shared LeNet5 parameter package.
REQ-024 Each bank SHALL be one instance of sub-module ifm_bank_ram (1 write port, 2 synchronous read ports); the top level SHALL hold the pointers, FSM and muxing.

Verification
REQ-025 Fill bank 0 with data=addr (0..195), then pulse start_from_previous -> start_to_next pulses 2 cycles later; A read of addr 5 and B read of addr 195 give 5 and 195 one cycle later.
REQ-026 Fill both banks before any end_from_next -> end_to_previous=0; one end_from_next -> end_to_previous=1 next cycle, start_to_next pulses for bank 1 one cycle after FSM reaches IDLE.
REQ-027 Write to full bank 0 (ifm_sel=0) -> contents unchanged, error=1.
REQ-028 end_from_next while IDLE -> error=1, pointers unchanged.
REQ-029 Same-cycle start_from_previous (bank 1) and end_from_next (bank 0) -> full=2'b10, rd_bank=1, then start_to_next pulses.
REQ-030 Assert reset while BUSY with full=2'b11 -> all outputs at reset values immediately, no start_to_next after release.
